// File: rtl/pipe_pkg.sv
// Shared types and default widths for the 5-stage pipeline boundary registers.
// ctrl_mem_t carries the control signals that travel from EX into MEM/WB.
package pipe_pkg;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic branch;
        logic mem_read;
        logic mem_write;
    } ctrl_mem_t;

    localparam ctrl_mem_t CTRL_BUBBLE = '0;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

endpackage

// File: rtl/ex_mem_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// It stops at all-ones and never wraps; clr overrides inc.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (inc && !(&count_reg)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline boundary register. It supports stall (hold), flush (bubble insertion) and squashing of control on invalid slots.
// It also keeps saturating stall and flush event counters for hazard-unit debug.
module ex_mem_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              cnt_clr,
    input  logic              in_valid,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic              branch_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [DATA_W-1:0] add_result_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] read_data_2_in,
    input  logic [ADDR_W-1:0] write_addr_in,
    input  logic              zero_in,
    output logic              out_valid,
    output logic              reg_write_out,
    output logic              mem_to_reg_out,
    output logic              branch_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic [DATA_W-1:0] add_result_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] read_data_2_out,
    output logic [ADDR_W-1:0] write_addr_out,
    output logic              zero_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    ctrl_mem_t         ctrl_in;
    ctrl_mem_t         ctrl_reg;
    logic              valid_reg;
    logic [DATA_W-1:0] add_result_reg;
    logic [DATA_W-1:0] alu_result_reg;
    logic [DATA_W-1:0] read_data_2_reg;
    logic [ADDR_W-1:0] write_addr_reg;
    logic              zero_reg;

    always_comb begin
        ctrl_in            = CTRL_BUBBLE;
        ctrl_in.reg_write  = reg_write_in;
        ctrl_in.mem_to_reg = mem_to_reg_in;
        ctrl_in.branch     = branch_in;
        ctrl_in.mem_read   = mem_read_in;
        ctrl_in.mem_write  = mem_write_in;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_reg       <= 1'b0;
            ctrl_reg        <= CTRL_BUBBLE;
            add_result_reg  <= '0;
            alu_result_reg  <= '0;
            read_data_2_reg <= '0;
            write_addr_reg  <= '0;
            zero_reg        <= 1'b0;
        end else if (!stall) begin
            valid_reg       <= in_valid;
            // An invalid slot must never cause a register-file or memory write.
            ctrl_reg        <= in_valid ? ctrl_in : CTRL_BUBBLE;
            add_result_reg  <= add_result_in;
            alu_result_reg  <= alu_result_in;
            read_data_2_reg <= read_data_2_in;
            write_addr_reg  <= write_addr_in;
            zero_reg        <= zero_in;
        end
    end

    assign out_valid       = valid_reg;
    assign reg_write_out   = ctrl_reg.reg_write;
    assign mem_to_reg_out  = ctrl_reg.mem_to_reg;
    assign branch_out      = ctrl_reg.branch;
    assign mem_read_out    = ctrl_reg.mem_read;
    assign mem_write_out   = ctrl_reg.mem_write;
    assign add_result_out  = add_result_reg;
    assign alu_result_out  = alu_result_reg;
    assign read_data_2_out = read_data_2_reg;
    assign write_addr_out  = write_addr_reg;
    assign zero_out        = zero_reg;

    // Flush outranks stall, so a combined request counts only as a flush.
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (stall && !flush),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (flush),
        .count (flush_cnt)
    );

endmodule
